// File: rtl/mem_ctl_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states,
// big-endian lane-select constants and the lane shift helper.
package mem_ctl_pkg;

    localparam logic [1:0] DS_WORD = 2'd0;
    localparam logic [1:0] DS_HALF = 2'd1;
    localparam logic [1:0] DS_BYTE = 2'd2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_F_RD   = 3'd1;
    localparam logic [2:0] ST_D_RD   = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_D_WR   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [4:0]  SHIFT_HALF_HI = 5'd16;
    localparam logic [4:0]  SHIFT_HALF_LO = 5'd0;
    localparam logic [4:0]  SHIFT_NONE    = 5'd0;
    localparam logic [31:0] MASK_HALF     = 32'h0000_FFFF;
    localparam logic [31:0] MASK_BYTE     = 32'h0000_00FF;

    // Big-endian: offset 0 is the most significant lane.
    function automatic logic [4:0] lane_shift(input logic [1:0] ds, input logic [1:0] ofs);
        logic [4:0] sh;
        case (ds)
            DS_HALF: sh = ofs[1] ? SHIFT_HALF_LO : SHIFT_HALF_HI;
            DS_BYTE: sh = {~ofs, 3'b000};
            default: sh = SHIFT_NONE;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mem_access_controller_load_extract.sv
// Combinational sub-word load extraction with sign or zero extension.
module load_extract
    import mem_ctl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [15:0] lane_s;

    // Shift the addressed lane down, then extend it to a full word.
    always_comb begin
        lane_s = 16'(word >> lane_shift(size, offset));
        case (size)
            DS_HALF: value = {(is_unsigned ? 16'h0000 : {16{lane_s[15]}}), lane_s};
            DS_BYTE: value = {(is_unsigned ? 24'h00_0000 : {24{lane_s[7]}}), lane_s[7:0]};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Arbitrates fetch and load/store onto one word-wide memory, with read-modify-write
// for sub-word stores. Optional alignment rejection via MEMCTL_ALIGN_CHECK_EN.
module mem_access_controller
    import mem_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_ds,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_fault,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    logic [2:0]  state_r;
    logic        fault_s;
    logic        sub_s;
    logic [4:0]  shift_s;
    logic [31:0] mask_s;
    logic [31:0] merge_s;
    logic [31:0] load_ext_s;
    logic        unused_s;

    assign unused_s = ^if_addr[1:0];

    load_extract u_load_extract (
        .word        (mem_rdata),
        .offset      (d_addr[1:0]),
        .size        (d_ds),
        .is_unsigned (d_unsigned),
        .value       (load_ext_s)
    );

`ifdef MEMCTL_ALIGN_CHECK_EN
    // Reject misaligned words/halves and the reserved size code.
    always_comb begin
        case (d_ds)
            DS_WORD: fault_s = (d_addr[1:0] != 2'b00);
            DS_HALF: fault_s = d_addr[0];
            DS_BYTE: fault_s = 1'b0;
            default: fault_s = 1'b1;
        endcase
    end
`else
    assign fault_s = 1'b0;
`endif

    // Merge the store lane into the word captured during the RMW read.
    always_comb begin
        shift_s = lane_shift(d_ds, d_addr[1:0]);
        case (d_ds)
            DS_HALF: begin
                sub_s  = 1'b1;
                mask_s = MASK_HALF << shift_s;
            end
            DS_BYTE: begin
                sub_s  = 1'b1;
                mask_s = MASK_BYTE << shift_s;
            end
            default: begin
                sub_s  = 1'b0;
                mask_s = 32'hFFFF_FFFF;
            end
        endcase
        merge_s = (mem_rdata & ~mask_s) | ((d_wdata << shift_s) & mask_s);
    end

    // Sequencing FSM; every memory-side and completion output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            d_fault   <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            if_rdata  <= 32'h0000_0000;
            d_rdata   <= 32'h0000_0000;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            d_fault <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (d_req) begin
                        busy     <= 1'b1;
                        mem_addr <= {d_addr[31:2], 2'b00};
                        if (fault_s) begin
                            state_r <= ST_DONE;
                            d_done  <= 1'b1;
                            d_fault <= 1'b1;
                        end else if (!d_we) begin
                            state_r <= ST_D_RD;
                            mem_rd  <= 1'b1;
                        end else if (sub_s) begin
                            state_r <= ST_RMW_RD;
                            mem_rd  <= 1'b1;
                        end else begin
                            state_r   <= ST_D_WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= d_wdata;
                        end
                    end else if (if_req) begin
                        busy     <= 1'b1;
                        state_r  <= ST_F_RD;
                        mem_rd   <= 1'b1;
                        mem_addr <= {if_addr[31:2], 2'b00};
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_F_RD: begin
                    if (mem_ready) begin
                        mem_rd   <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_D_RD: begin
                    if (mem_ready) begin
                        mem_rd  <= 1'b0;
                        d_rdata <= load_ext_s;
                        d_done  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_RMW_RD: begin
                    if (mem_ready) begin
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merge_s;
                        state_r   <= ST_D_WR;
                    end
                end
                ST_D_WR: begin
                    if (mem_ready) begin
                        mem_wr  <= 1'b0;
                        d_done  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
